// File: rtl/drygascon128_host_seq_if.sv
// Host-side streams of the drygascon128 sequencer: command, input words, output words.
// The mode controller uses the master view; the sequencer uses the slave view.
interface drygascon128_host_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_ds;
   logic [3:0]  cmd_rounds;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;

   modport master (
      output cmd_valid, cmd_op, cmd_ds, cmd_rounds, s_valid, s_data, m_ready,
      input  cmd_ready, s_ready, m_valid, m_data
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_ds, cmd_rounds, s_valid, s_data, m_ready,
      output cmd_ready, s_ready, m_valid, m_data
   );
endinterface

// File: rtl/drygascon128_host_seq.sv
// Command sequencer for one drygascon128 F/G core: counts word writes, starts the core,
// waits for completion and streams R/C words back through a small output FIFO.
//
// state | meaning
// IDLE  | waiting for a command; ready only with core idle and FIFO empty
// LOAD  | passing input words to the core, one wr_* per handshake
// START | single-cycle core start pulse
// WAIT  | core running; first cycle ignores core_idle
// READ  | issuing rd_* pulses while the FIFO has room for the result
// DRAIN | final read word being captured
module drygascon128_host_seq #(
   parameter logic [3:0] DEFAULT_ROUNDS = 4'd11,
   parameter int         OUT_DEPTH      = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   drygascon128_host_seq_if.slave        host,
   output logic                          busy,
   output logic                          err,
   output logic [31:0]                   core_din,
   output logic [3:0]                    core_ds,
   output logic [3:0]                    core_rounds,
   output logic                          core_wr_i,
   output logic                          core_wr_c,
   output logic                          core_wr_x,
   output logic                          core_start,
   output logic                          core_rd_r,
   output logic                          core_rd_c,
   input  logic [31:0]                   core_dout,
   input  logic                          core_idle
);
   localparam int PW = $clog2(OUT_DEPTH);
   localparam int CW = $clog2(OUT_DEPTH + 1);

   localparam logic [2:0] OP_LOAD_C     = 3'd0;
   localparam logic [2:0] OP_LOAD_X     = 3'd1;
   localparam logic [2:0] OP_ABSORB     = 3'd2;
   localparam logic [2:0] OP_ABSORB_OUT = 3'd3;
   localparam logic [2:0] OP_G_OUT      = 3'd4;
   localparam logic [2:0] OP_READ_C     = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [3:0]    ds_q, ds_d;
   logic [3:0]    rounds_q, rounds_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [3:0]    nwords_q, nwords_d;
   logic          wait_first_q, wait_first_d;
   logic          inflight_q, inflight_d;
   logic          err_q, err_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   mem_q [OUT_DEPTH];

   logic          cmd_fire, s_fire, rd_fire, push, pop, last_word, room;
   logic [CW:0]   occ;

   assign cmd_fire  = host.cmd_valid && host.cmd_ready;
   assign s_fire    = host.s_valid && host.s_ready;
   assign rd_fire   = core_rd_r || core_rd_c;
   assign last_word = (wcnt_q == nwords_q - 4'd1);
   assign push      = inflight_q;
   assign pop       = host.m_valid && host.m_ready;
   // A read already in flight has a FIFO slot reserved for its word.
   assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign room      = (occ < (CW+1)'(OUT_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         ds_q         <= '0;
         rounds_q     <= '0;
         wcnt_q       <= '0;
         nwords_q     <= '0;
         wait_first_q <= 1'b0;
         inflight_q   <= 1'b0;
         err_q        <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         ds_q         <= ds_d;
         rounds_q     <= rounds_d;
         wcnt_q       <= wcnt_d;
         nwords_q     <= nwords_d;
         wait_first_q <= wait_first_d;
         inflight_q   <= inflight_d;
         err_q        <= err_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= core_dout;
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      ds_d         = ds_q;
      rounds_d     = rounds_q;
      wcnt_d       = wcnt_q;
      nwords_d     = nwords_q;
      wait_first_d = 1'b0;
      inflight_d   = rd_fire;
      err_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               wcnt_d = '0;
               if (host.cmd_op > OP_READ_C) begin
                  err_d = 1'b1;
               end else begin
                  op_d     = host.cmd_op;
                  ds_d     = host.cmd_ds;
                  rounds_d = (host.cmd_rounds == 4'd0) ? DEFAULT_ROUNDS : host.cmd_rounds;
                  case (host.cmd_op)
                     OP_LOAD_C: begin
                        nwords_d = 4'd10;
                        state_d  = S_LOAD;
                     end
                     OP_G_OUT:  state_d = S_START;
                     OP_READ_C: begin
                        nwords_d = 4'd10;
                        state_d  = S_READ;
                     end
                     default: begin
                        nwords_d = 4'd4;
                        state_d  = S_LOAD;
                     end
                  endcase
               end
            end
         end
         S_LOAD: begin
            if (s_fire) begin
               if (last_word) begin
                  wcnt_d  = '0;
                  state_d = (op_q == OP_LOAD_C || op_q == OP_LOAD_X) ? S_IDLE : S_START;
               end else begin
                  wcnt_d = wcnt_q + 4'd1;
               end
            end
         end
         S_START: begin
            wait_first_d = 1'b1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (!wait_first_q && core_idle) begin
               if (op_q == OP_ABSORB) begin
                  state_d = S_IDLE;
               end else begin
                  nwords_d = 4'd4;
                  state_d  = S_READ;
               end
            end
         end
         S_READ: begin
            if (rd_fire) begin
               if (last_word) begin
                  wcnt_d  = '0;
                  state_d = S_DRAIN;
               end else begin
                  wcnt_d = wcnt_q + 4'd1;
               end
            end
         end
         // DRAIN always follows the last rd, so its word lands on this edge.
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = (wptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_d = (rptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_comb begin
      host.cmd_ready = 1'b0;
      host.s_ready   = 1'b0;
      core_din       = '0;
      core_wr_i      = 1'b0;
      core_wr_c      = 1'b0;
      core_wr_x      = 1'b0;
      core_start     = 1'b0;
      core_rd_r      = 1'b0;
      core_rd_c      = 1'b0;
      case (state_q)
         S_IDLE: host.cmd_ready = core_idle && (count_q == '0);
         S_LOAD: begin
            host.s_ready = core_idle;
            if (host.s_valid && core_idle) begin
               core_din  = host.s_data;
               core_wr_c = (op_q == OP_LOAD_C);
               core_wr_x = (op_q == OP_LOAD_X);
               core_wr_i = (op_q != OP_LOAD_C) && (op_q != OP_LOAD_X);
            end
         end
         S_START: core_start = 1'b1;
         S_READ: begin
            if (core_idle && room) begin
               core_rd_c = (op_q == OP_READ_C);
               core_rd_r = (op_q != OP_READ_C);
            end
         end
         default: ;
      endcase
   end

   assign host.m_valid = (count_q != '0);
   assign host.m_data  = host.m_valid ? mem_q[rptr_q] : '0;
   assign busy         = (state_q != S_IDLE) || (count_q != '0);
   assign err          = err_q;
   assign core_ds      = ds_q;
   assign core_rounds  = rounds_q;
endmodule

// File: tb/tb_drygascon128_host_seq.sv
// Directed and randomized checks of drygascon128_host_seq against a behavioural core mock
// and a word-level reference of what each command should write and return.
module tb_drygascon128_host_seq;
   logic        clk, rst_n;
   logic        busy, err;
   logic [31:0] core_din, core_dout;
   logic [3:0]  core_ds, core_rounds;
   logic        core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c, core_idle;

   drygascon128_host_seq_if hif();

   drygascon128_host_seq dut (
      .clk(clk), .rst_n(rst_n), .host(hif.slave), .busy(busy), .err(err),
      .core_din(core_din), .core_ds(core_ds), .core_rounds(core_rounds),
      .core_wr_i(core_wr_i), .core_wr_c(core_wr_c), .core_wr_x(core_wr_x),
      .core_start(core_start), .core_rd_r(core_rd_r), .core_rd_c(core_rd_c),
      .core_dout(core_dout), .core_idle(core_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core mock: word counters wrap at their natural sizes; R words are tagged with the start index.
   logic [31:0] c_mem [10];
   logic [31:0] x_mem [4];
   int          cw, xw, iw, crd, rrd, bcnt, nstart_core, r_idx;
   logic        core_run, lag;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_idle <= 1'b1; core_dout <= '0; core_run <= 1'b0; lag <= 1'b0;
         cw <= 0; xw <= 0; iw <= 0; crd <= 0; rrd <= 0; bcnt <= 0;
         nstart_core <= 0; r_idx <= 0;
      end else begin
         if (core_wr_c) begin c_mem[cw] <= core_din; cw <= (cw == 9) ? 0 : cw + 1; end
         if (core_wr_x) begin x_mem[xw] <= core_din; xw <= (xw == 3) ? 0 : xw + 1; end
         if (core_wr_i) iw <= (iw == 3) ? 0 : iw + 1;
         if (core_rd_c) begin core_dout <= c_mem[crd]; crd <= (crd == 9) ? 0 : crd + 1; end
         if (core_rd_r) begin
            core_dout <= 32'h5200_0000 | (32'(r_idx & 255) << 8) | 32'(rrd);
            rrd <= (rrd == 3) ? 0 : rrd + 1;
         end
         if (core_start) begin
            core_run <= 1'b1; lag <= 1'b1;
            r_idx <= nstart_core; nstart_core <= nstart_core + 1;
         end else if (lag) begin
            lag <= 1'b0; core_idle <= 1'b0; bcnt <= int'($urandom_range(2, 7));
         end else if (!core_idle) begin
            if (bcnt == 0) begin core_idle <= 1'b1; core_run <= 1'b0; end
            else bcnt <= bcnt - 1;
         end
      end
   end

   // Monitor: sampled mid-cycle, away from the active edge.
   int          n_wrc, n_wrx, n_wri, n_start, n_rdr, n_rdc, n_err;
   int          viol_busy, viol_gap, viol_multi, viol_ready;
   int          din_n, got_n;
   logic [31:0] din_log [1024];
   logic [31:0] got_log [1024];
   logic [3:0]  start_ds, start_rounds;

   always @(negedge clk) begin
      if (rst_n) begin
         if (core_wr_c) n_wrc++;
         if (core_wr_x) n_wrx++;
         if (core_wr_i) n_wri++;
         if (core_start) begin n_start++; start_ds = core_ds; start_rounds = core_rounds; end
         if (core_rd_r) n_rdr++;
         if (core_rd_c) n_rdc++;
         if (err) n_err++;
         if ((core_wr_c || core_wr_x || core_wr_i) && din_n < 1024) begin
            din_log[din_n] = core_din; din_n++;
         end
         if ((core_wr_c || core_wr_x || core_wr_i || core_rd_r || core_rd_c) && (!core_idle || core_run))
            viol_busy++;
         if ((core_wr_c || core_wr_x || core_wr_i) && !hif.s_valid) viol_gap++;
         if ($countones({core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r, core_rd_c}) > 1)
            viol_multi++;
         if (hif.cmd_ready && (!core_idle || core_run)) viol_ready++;
         if (hif.m_valid && hif.m_ready && got_n < 1024) begin
            got_log[got_n] = hif.m_data; got_n++;
         end
      end
   end

   int          n_tests, n_fail;
   int          mr_mode;
   int          ref_nstart;
   logic [31:0] c_ref [10];
   logic [31:0] txq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rounds);
      int t = 0;
      hif.cmd_valid = 1'b1; hif.cmd_op = op; hif.cmd_ds = ds; hif.cmd_rounds = rounds;
      @(negedge clk);
      while (!hif.cmd_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) chk("cmd_accept_timeout", t, 0);
      step();
      hif.cmd_valid = 1'b0; hif.cmd_op = 3'($urandom); hif.cmd_ds = 4'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      int t = 0;
      hif.s_valid = 1'b0;
      repeat (gap) step();
      hif.s_valid = 1'b1; hif.s_data = w;
      @(negedge clk);
      while (!hif.s_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) chk("s_ready_timeout", t, 0);
      step();
      hif.s_valid = 1'b0; hif.s_data = $urandom;
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while ((busy || !hif.cmd_ready) && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) chk("done_timeout", t, 0);
      step();
   endtask

   // gapmode: 0 back-to-back, 1 one idle cycle between words, 2 random 0..2 idle cycles.
   task automatic run_op(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] rounds,
                         input int gapmode, input int hold);
      int          nw_in, gap, saved_mode;
      int          b_wrc, b_wrx, b_wri, b_st, b_rdr, b_rdc, d0, g0;
      logic [31:0] exp_w [$];
      logic [3:0]  eff_rounds;
      b_wrc = n_wrc; b_wrx = n_wrx; b_wri = n_wri; b_st = n_start;
      b_rdr = n_rdr; b_rdc = n_rdc; d0 = din_n; g0 = got_n;
      nw_in = (op == 3'd0) ? 10 : (op <= 3'd3) ? 4 : 0;
      eff_rounds = (rounds == 4'd0) ? 4'd11 : rounds;
      if (op == 3'd3 || op == 3'd4)
         for (int k = 0; k < 4; k++) exp_w.push_back(32'h5200_0000 | (32'(ref_nstart & 255) << 8) | 32'(k));
      if (op == 3'd5)
         for (int k = 0; k < 10; k++) exp_w.push_back(c_ref[k]);
      saved_mode = mr_mode;
      if (hold > 0) mr_mode = 0;
      send_cmd(op, ds, rounds);
      for (int i = 0; i < nw_in; i++) begin
         gap = (gapmode == 0) ? 0 : (gapmode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(0, 2));
         send_word(txq[i], gap);
      end
      if (hold > 0) begin
         repeat (hold) step();
         chk("hold_rd_at_most_2", 32'((n_rdr - b_rdr) <= 2), 32'd1);
         chk("hold_m_valid", 32'(hif.m_valid), 32'd1);
         mr_mode = (saved_mode == 0) ? 1 : saved_mode;
      end
      wait_done();
      mr_mode = saved_mode;
      chk("wr_c_count", n_wrc - b_wrc, (op == 3'd0) ? 10 : 0);
      chk("wr_x_count", n_wrx - b_wrx, (op == 3'd1) ? 4 : 0);
      chk("wr_i_count", n_wri - b_wri, (op == 3'd2 || op == 3'd3) ? 4 : 0);
      chk("start_count", n_start - b_st, (op >= 3'd2 && op <= 3'd4) ? 1 : 0);
      chk("rd_r_count", n_rdr - b_rdr, (op == 3'd3 || op == 3'd4) ? 4 : 0);
      chk("rd_c_count", n_rdc - b_rdc, (op == 3'd5) ? 10 : 0);
      for (int i = 0; i < nw_in; i++) chk("core_din_word", din_log[d0 + i], txq[i]);
      chk("out_word_count", got_n - g0, exp_w.size());
      for (int i = 0; i < exp_w.size() && g0 + i < got_n; i++) chk("out_word", got_log[g0 + i], exp_w[i]);
      if (op >= 3'd2 && op <= 3'd4) begin
         chk("start_core_ds", 32'(start_ds), 32'(ds));
         chk("start_core_rounds", 32'(start_rounds), 32'(eff_rounds));
      end
      chk("core_counters_wrapped", cw + xw + iw + crd + rrd, 0);
      if (op == 3'd0) for (int k = 0; k < 10; k++) c_ref[k] = txq[k];
      if (op >= 3'd2 && op <= 3'd4) ref_nstart++;
   endtask

   task automatic fill_random(input int n);
      txq.delete();
      for (int i = 0; i < n; i++) txq.push_back($urandom);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(hif.cmd_ready), 32'd1);
      chk({tag, "_s_ready"}, 32'(hif.s_ready), 32'd0);
      chk({tag, "_m_valid"}, 32'(hif.m_valid), 32'd0);
      chk({tag, "_m_data"}, hif.m_data, 32'd0);
      chk({tag, "_busy_err"}, {30'd0, busy, err}, 32'd0);
      chk({tag, "_core_pulses"},
          32'({core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c}), 32'd0);
      chk({tag, "_core_ds_rounds"}, 32'({core_ds, core_rounds}), 32'd0);
      chk({tag, "_core_din"}, core_din, 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_err, b_tot, t;
      logic [2:0] rop;
      hif.cmd_valid = 1'b0; hif.cmd_op = '0; hif.cmd_ds = '0; hif.cmd_rounds = '0;
      hif.s_valid = 1'b0; hif.s_data = '0; hif.m_ready = 1'b0;
      rst_n = 1'b0; mr_mode = 0; ref_nstart = 0;
      fork
         forever begin
            @(posedge clk); #2;
            hif.m_ready = (mr_mode == 2) ? 1'($urandom) : (mr_mode == 1);
         end
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      step(); rst_n = 1'b1;
      step();
      mr_mode = 1;

      txq.delete();
      for (int i = 0; i < 10; i++) txq.push_back(32'(i));
      run_op(3'd0, 4'd0, 4'd0, 1, 0);

      fill_random(4);
      run_op(3'd2, 4'h3, 4'd0, 2, 0);

      run_op(3'd4, 4'($urandom), 4'($urandom), 0, 20);

      mr_mode = 2;
      txq.delete();
      for (int i = 0; i < 10; i++) txq.push_back(32'hA5A5_0000 + 32'(i));
      run_op(3'd0, 4'd0, 4'd0, 2, 0);
      run_op(3'd5, 4'd0, 4'd0, 0, 0);
      chk("read_c_core_counter", crd, 0);

      b_err = n_err;
      b_tot = n_wrc + n_wrx + n_wri + n_start + n_rdr + n_rdc;
      send_cmd(3'd7, 4'($urandom), 4'($urandom));
      repeat (3) step();
      chk("illegal_err_one_cycle", n_err - b_err, 1);
      chk("illegal_no_core_pulse", n_wrc + n_wrx + n_wri + n_start + n_rdr + n_rdc - b_tot, 0);
      chk("illegal_busy", 32'(busy), 32'd0);
      fill_random(4);
      run_op(3'd1, 4'($urandom), 4'($urandom), 2, 0);
      for (int k = 0; k < 4; k++) chk("x_mem_word", x_mem[k], txq[k]);

      for (int it = 0; it < 10; it++) begin
         rop = 3'($urandom_range(0, 5));
         fill_random(10);
         run_op(rop, 4'($urandom), 4'($urandom), 2, 0);
      end

      fill_random(4);
      send_cmd(3'd3, 4'h9, 4'd5);
      for (int i = 0; i < 4; i++) send_word(txq[i], 0);
      t = 0;
      @(negedge clk);
      while (!core_start && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("start_before_reset_timeout", t, 0);
      step(); step();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (3) step();
      rst_n = 1'b1;
      ref_nstart = 0;
      @(negedge clk);
      chk("post_reset_cmd_ready", 32'(hif.cmd_ready), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);
      step();
      run_op(3'd4, 4'($urandom), 4'd0, 0, 0);

      chk("viol_pulse_while_core_busy", viol_busy, 0);
      chk("viol_wr_without_s_valid", viol_gap, 0);
      chk("viol_multiple_core_pulses", viol_multi, 0);
      chk("viol_cmd_ready_while_core_busy", viol_ready, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
